front_panel_display: RTL and testbench
======================================

# front_panel_display

Multiplexed six-digit seven-segment display driver for the front panel: 4 address digits, 2 data digits, one decimal point per digit. It is the output-side counterpart to the panel key-matrix scanner and uses the same time-sliced drive scheme. Display values are captured into a shadow buffer on a load strobe and committed at frame boundaries, so a displayed frame never mixes old and new values. Per-digit PWM sets brightness, and a dead-time window suppresses ghosting.

## Interface
- SLOT_BITS, 15: width of the per-digit slot counter; one slot is 2^SLOT_BITS cycles.
- DEAD_CYCLES, 64: blanking cycles at the start of each slot. Constraint: DEAD_CYCLES < 2^(SLOT_BITS-3).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- disp_addr  in  16  address field; [15:12] drives digit 0 (leftmost), [3:0] drives digit 3.
- disp_data  in  8  data field; [7:4] drives digit 4, [3:0] drives digit 5.
- disp_dp  in  6  decimal point per digit; bit n belongs to digit n.
- load  in  1  single-cycle strobe; captures disp_addr, disp_data and disp_dp into the shadow buffer.
- pending  out  1  high from the cycle after load until the shadow buffer is committed.
- bright  in  3  brightness; each slot is lit for (bright+1)/8 of its length, minus dead time.
- DISP_dig  out  6  one-hot digit enable, active high; DISP_dig[n] enables digit n.
- DISP_seg  out  8  {dp,g,f,e,d,c,b,a}, active high.
- frame_start  out  1  one-cycle pulse on the first cycle of the digit-0 slot.

## Operation
Reset state:
- slot_cnt = 0, digit index = 0.
- Shadow and active buffers all zero.
- pending = 0, DISP_dig = 0, DISP_seg = 0, frame_start = 0.

Scan:
- slot_cnt increments every cycle and wraps at all-ones.
- On each wrap the digit index advances 0→1→…→5→0. Going from 5 to 0 is the frame boundary.
- A digit is lit when slot_cnt >= DEAD_CYCLES AND slot_cnt[SLOT_BITS-1:SLOT_BITS-3] <= bright.
- When lit: DISP_dig = one-hot(index) and DISP_seg = {dp, hex7(nibble)}. Otherwise both are 0.

hex7 encoding ({g..a}): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.

Buffering:
- load writes the shadow buffer and sets pending.
- A second load before commit overwrites the shadow; the latest load wins.
- Commit happens on the last cycle of the frame (index 5, slot_cnt all-ones) only if pending = 1: active ← shadow, pending ← 0.
- If load coincides with the commit cycle: active takes the pre-load shadow contents, the shadow takes the new values, and pending stays 1 so the new values commit at the next boundary.
- The display always renders from the active buffer.

## Timing
- DISP_dig, DISP_seg and frame_start are registered. In cycle t+1 they reflect the counter and active-buffer state of cycle t.
- The first lit cycle of a slot is the cycle after slot_cnt = DEAD_CYCLES.
- The last lit cycle is the cycle after slot_cnt = ((bright+1)·2^(SLOT_BITS-3))-1.
- Lit cycles per slot = (bright+1)·2^(SLOT_BITS-3) − DEAD_CYCLES.
- A bright change takes effect on the next cycle's comparison; no frame alignment.
- frame_start goes high in the cycle after the frame boundary, coincident with the first output cycle of slot 0.
- Frame period = 6·2^SLOT_BITS cycles.
- Load-to-display latency: at most one frame plus one cycle.
- Asserting rst_n low mid-slot forces every register and output to its reset value immediately. pending clears and shadow contents are lost.

## Configuration
- DISP_LEADING_ZERO_BLANK_EN defined: leading-zero blanking on digits 0–2.
  - Digit n (n ≤ 2) drives g..a = 0 when its nibble and every nibble to its left are zero.
  - The DP bit is still driven, and DISP_dig still asserts in the slot.
  - Digit 3 and the data digits are never blanked.
- Macro undefined: all six digits always show their hex glyph.

## Test plan
Run all scenarios with SLOT_BITS=6 and DEAD_CYCLES=4.
1. Reset release with bright=7 → digit n lit in slot n for 60 cycles per slot (cycles 4–63), DISP_seg=0x3F (0x00 on digits 0–2 with DISP_LEADING_ZERO_BLANK_EN), frame_start every 384 cycles.
2. load with addr=0x1234, data=0xAB, dp=6'b000001 mid-frame → pending=1 until the boundary. The next frame shows 0x86, 0x5B, 0x4F, 0x66, 0x77, 0x7C on digits 0–5; no frame mixes old and new values.
3. bright=0 → 4 lit cycles per slot (cycles 4–7). bright=3 → 28 lit cycles (cycles 4–31).
4. Two loads in one frame (0x1111, then 0x2222) → only 0x2222 is displayed. A load on the commit cycle → the old shadow commits, pending stays 1, and the new value appears one frame later.
5. rst_n low in slot 3 at slot_cnt=20 → DISP_dig, DISP_seg and pending drop to 0 in the same cycle. After release, scanning restarts at digit 0 showing zeros.
6. DISP_LEADING_ZERO_BLANK_EN with addr=0x00A0 → digits 0 and 1 segments 0x00, digit 2 0x77, digit 3 0x3F. With addr=0x0000 → digit 3 still 0x3F.

Source files
------------

// File: rtl/front_panel_display.sv
// Six-digit multiplexed 7-seg driver with shadow/active buffering, PWM brightness and dead time.
// Latency: outputs registered, one cycle behind counter/buffer state; load commits at the next frame boundary.
// No backpressure: load is always accepted. DISP_LEADING_ZERO_BLANK_EN enables leading-zero blanking on digits 0-2.
module front_panel_display #(
    parameter int SLOT_BITS   = 15,
    parameter int DEAD_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] disp_addr,
    input  logic [7:0]  disp_data,
    input  logic [5:0]  disp_dp,
    input  logic        load,
    output logic        pending,
    input  logic [2:0]  bright,
    output logic [5:0]  DISP_dig,
    output logic [7:0]  DISP_seg,
    output logic        frame_start
);

    localparam logic [SLOT_BITS-1:0] DEAD = SLOT_BITS'(DEAD_CYCLES);

    logic [SLOT_BITS-1:0] slot_cnt;
    logic [2:0]           dig_idx;
    logic [15:0]          shadow_addr, active_addr;
    logic [7:0]           shadow_data, active_data;
    logic [5:0]           shadow_dp, active_dp;

    logic       slot_end, frame_end, lit, blank;
    logic [3:0] nibble;
    logic [6:0] glyph;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign slot_end  = &slot_cnt;
    assign frame_end = slot_end && (dig_idx == 3'd5);
    // Dead time blanks the start of every slot; the top three counter bits form the PWM phase.
    assign lit       = (slot_cnt >= DEAD) && (slot_cnt[SLOT_BITS-1 -: 3] <= bright);

    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        case (dig_idx)
            3'd0:    nibble = active_addr[15:12];
            3'd1:    nibble = active_addr[11:8];
            3'd2:    nibble = active_addr[7:4];
            3'd3:    nibble = active_addr[3:0];
            3'd4:    nibble = active_data[7:4];
            default: nibble = active_data[3:0];
        endcase
`ifdef DISP_LEADING_ZERO_BLANK_EN
        case (dig_idx)
            3'd0:    blank = (active_addr[15:12] == 4'h0);
            3'd1:    blank = (active_addr[15:8] == 8'h00);
            3'd2:    blank = (active_addr[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
`endif
        glyph = blank ? 7'h00 : hex7(nibble);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            dig_idx     <= 3'd0;
            shadow_addr <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            active_addr <= '0;
            active_data <= '0;
            active_dp   <= '0;
            pending     <= 1'b0;
            DISP_dig    <= '0;
            DISP_seg    <= '0;
            frame_start <= 1'b0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_end)
                dig_idx <= (dig_idx == 3'd5) ? 3'd0 : dig_idx + 3'd1;

            // Commit reads the pre-load shadow, so a load on this cycle waits a full frame.
            if (frame_end && pending) begin
                active_addr <= shadow_addr;
                active_data <= shadow_data;
                active_dp   <= shadow_dp;
                pending     <= 1'b0;
            end
            if (load) begin
                shadow_addr <= disp_addr;
                shadow_data <= disp_data;
                shadow_dp   <= disp_dp;
                pending     <= 1'b1;
            end

            DISP_dig    <= lit ? (6'd1 << dig_idx) : 6'd0;
            DISP_seg    <= lit ? {active_dp[dig_idx], glyph} : 8'd0;
            frame_start <= (dig_idx == 3'd0) && (slot_cnt == '0);
        end
    end

endmodule

// File: tb/tb_front_panel_display.sv
// Scoreboard bench for front_panel_display at SLOT_BITS=6, DEAD_CYCLES=4 (slot 64, frame 384 cycles).
module tb_front_panel_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] disp_addr;
    logic [7:0]  disp_data;
    logic [5:0]  disp_dp;
    logic        load;
    logic        pending;
    logic [2:0]  bright;
    logic [5:0]  DISP_dig;
    logic [7:0]  DISP_seg;
    logic        frame_start;

    always #5 clk = ~clk;

    front_panel_display #(.SLOT_BITS(6), .DEAD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .disp_addr(disp_addr), .disp_data(disp_data),
        .disp_dp(disp_dp), .load(load), .pending(pending), .bright(bright),
        .DISP_dig(DISP_dig), .DISP_seg(DISP_seg), .frame_start(frame_start)
    );

    typedef struct packed {
        logic [5:0] dig;
        logic [7:0] seg;
        logic       fs;
        logic       pend;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    int          m_cnt, m_idx;
    logic [15:0] m_sh_a, m_ac_a;
    logic [7:0]  m_sh_d, m_ac_d;
    logic [5:0]  m_sh_p, m_ac_p;
    logic        m_pend;

    int         lit_cnt, fs_cnt;
    logic [7:0] seen [6];

    logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

`ifdef DISP_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] ZERO_LEAD = 8'h00;
`else
    localparam logic [7:0] ZERO_LEAD = 8'h3F;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_pend = 1'b0;
        m_sh_a = '0; m_sh_d = '0; m_sh_p = '0;
        m_ac_a = '0; m_ac_d = '0; m_ac_p = '0;
        sb_q.delete();
    endtask

    task automatic tick();
        exp_t       e, got_e;
        logic [3:0] n;
        logic [6:0] g;
        logic       lit, commit;
        lit = (m_cnt >= 4) && ((m_cnt / 8) <= int'(bright));
        case (m_idx)
            0:       n = m_ac_a[15:12];
            1:       n = m_ac_a[11:8];
            2:       n = m_ac_a[7:4];
            3:       n = m_ac_a[3:0];
            4:       n = m_ac_d[7:4];
            default: n = m_ac_d[3:0];
        endcase
        g = glyph_tbl[n];
`ifdef DISP_LEADING_ZERO_BLANK_EN
        if (m_idx <= 2 && (m_ac_a >> (4 * (3 - m_idx))) == 16'h0) g = 7'h00;
`endif
        e.dig  = lit ? 6'(1 << m_idx) : 6'd0;
        e.seg  = lit ? {m_ac_p[m_idx], g} : 8'd0;
        e.fs   = (m_cnt == 0) && (m_idx == 0);
        commit = (m_idx == 5) && (m_cnt == 63) && m_pend;
        e.pend = load ? 1'b1 : (commit ? 1'b0 : m_pend);
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        got_e = sb_q.pop_front();
        chk("dig", DISP_dig, got_e.dig);
        chk("seg", DISP_seg, got_e.seg);
        chk("frame_start", frame_start, got_e.fs);
        chk("pending", pending, got_e.pend);
        if (DISP_dig != 6'd0) lit_cnt++;
        if (frame_start) fs_cnt++;
        for (int d = 0; d < 6; d++)
            if (DISP_dig == 6'(1 << d)) seen[d] = DISP_seg;

        if (commit) begin
            m_ac_a = m_sh_a; m_ac_d = m_sh_d; m_ac_p = m_sh_p;
        end
        if (load) begin
            m_sh_a = disp_addr; m_sh_d = disp_data; m_sh_p = disp_dp;
        end
        m_pend = e.pend;
        m_cnt  = m_cnt + 1;
        if (m_cnt == 64) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 6;
        end
    endtask

    task automatic pulse_load(input logic [15:0] a, input logic [7:0] d, input logic [5:0] p);
        disp_addr = a; disp_data = d; disp_dp = p; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // idx < 0 matches any digit.
    task automatic run_until(input int idx, input int cnt);
        int k = 0;
        while (!((idx < 0 || m_idx == idx) && m_cnt == cnt) && k < 1000) begin
            tick();
            k++;
        end
        if (k >= 1000) chk("sync_timeout", 32'(k), 32'd0);
    endtask

    task automatic count_span(input int cycles);
        lit_cnt = 0; fs_cnt = 0;
        for (int d = 0; d < 6; d++) seen[d] = 8'hEE;
        repeat (cycles) tick();
    endtask

    initial begin
        rst_n = 1'b0; disp_addr = '0; disp_data = '0; disp_dp = '0; load = 1'b0; bright = 3'd7;
        model_reset();
        #12;
        chk("rst_dig", DISP_dig, 6'd0);
        chk("rst_seg", DISP_seg, 8'd0);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_pend", pending, 1'b0);
        rst_n = 1'b1;

        // Full frame at brightness 7 after reset.
        run_until(0, 0);
        count_span(384);
        chk("f1_lit", lit_cnt, 360);
        chk("f1_fs", fs_cnt, 1);
        chk("f1_d0", seen[0], ZERO_LEAD);
        chk("f1_d3", seen[3], 8'h3F);
        chk("f1_d5", seen[5], 8'h3F);

        // Mid-frame load commits at the boundary.
        repeat (100) tick();
        pulse_load(16'h1234, 8'hAB, 6'b000001);
        chk("load_pend", pending, 1'b1);
        run_until(0, 0);
        count_span(384);
        chk("g_d0", seen[0], 8'h86);
        chk("g_d1", seen[1], 8'h5B);
        chk("g_d2", seen[2], 8'h4F);
        chk("g_d3", seen[3], 8'h66);
        chk("g_d4", seen[4], 8'h77);
        chk("g_d5", seen[5], 8'h7C);

        // Brightness.
        bright = 3'd0;
        run_until(-1, 0);
        count_span(64);
        chk("bright0_lit", lit_cnt, 4);
        bright = 3'd3;
        run_until(-1, 0);
        count_span(64);
        chk("bright3_lit", lit_cnt, 28);
        bright = 3'd7;

        // Two loads in one frame: latest wins.
        run_until(0, 0);
        pulse_load(16'h1111, 8'h00, 6'd0);
        repeat (20) tick();
        pulse_load(16'h2222, 8'h00, 6'd0);
        run_until(0, 0);
        count_span(384);
        chk("latest_d0", seen[0], 8'h5B);
        chk("latest_d3", seen[3], 8'h5B);

        // Load on the commit cycle.
        pulse_load(16'h3333, 8'h00, 6'd0);
        run_until(5, 63);
        pulse_load(16'h4444, 8'h00, 6'd0);
        chk("commit_load_pend", pending, 1'b1);
        count_span(384);
        chk("old_shadow_d0", seen[0], 8'h4F);
        chk("pend_after_frame", pending, 1'b0);
        count_span(384);
        chk("new_shadow_d0", seen[0], 8'h66);

        // Asynchronous reset mid-slot.
        pulse_load(16'h5555, 8'h55, 6'h3F);
        run_until(3, 20);
        rst_n = 1'b0;
        #1;
        chk("arst_dig", DISP_dig, 6'd0);
        chk("arst_seg", DISP_seg, 8'd0);
        chk("arst_pend", pending, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        count_span(384);
        chk("post_rst_lit", lit_cnt, 360);
        chk("post_rst_d0", seen[0], ZERO_LEAD);
        chk("post_rst_d4", seen[4], 8'h3F);

        // Leading-zero patterns.
        pulse_load(16'h00A0, 8'h00, 6'd0);
        run_until(0, 0);
        count_span(384);
        chk("lz_d0", seen[0], ZERO_LEAD);
        chk("lz_d1", seen[1], ZERO_LEAD);
        chk("lz_d2", seen[2], 8'h77);
        chk("lz_d3", seen[3], 8'h3F);
        pulse_load(16'h0000, 8'h00, 6'b000100);
        run_until(0, 0);
        count_span(384);
        chk("lz0_d2_dp", seen[2], {1'b1, ZERO_LEAD[6:0]});
        chk("lz0_d3", seen[3], 8'h3F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
